// File: rtl/cart_slot_config_pkg.sv
//------------------------------------------------------------------------------
// cart_slot_config_pkg
//   Shared MSX cartridge types: machine type, decoded cartridge type, mapper,
//   per-slot configuration record, OSD type-selection codes and the state
//   encoding of the configuration-change tracker.
//   Ports: none (package).
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cart_slot_config_pkg;

  typedef enum logic {
    MSX1 = 1'b0,
    MSX2 = 1'b1
  } MSX_typ_t;

  // Decoded cartridge type carried in the configuration record.
  typedef enum logic [2:0] {
    CART_TYP_ROM    = 3'd0,
    CART_TYP_SCC    = 3'd1,
    CART_TYP_SCC2   = 3'd2,
    CART_TYP_FM_PAC = 3'd3,
    CART_TYP_MFRSD  = 3'd4,
    CART_TYP_GM2    = 3'd5,
    CART_TYP_FDC    = 3'd6,
    CART_TYP_EMPTY  = 3'd7
  } cart_typ_t;

  typedef logic [3:0] mapper_typ_t;

  typedef struct packed {
    cart_typ_t   typ;
    mapper_typ_t selected_mapper;
    logic [7:0]  selected_sram_size;  // kB
  } config_cart_t;

  // Raw OSD type-selection code per slot.
  typedef enum logic [2:0] {
    CART_SEL_ROM    = 3'd0,
    CART_SEL_SCC    = 3'd1,
    CART_SEL_SCC2   = 3'd2,
    CART_SEL_FM_PAC = 3'd3,
    CART_SEL_MFRSD  = 3'd4,
    CART_SEL_GM2    = 3'd5,
    CART_SEL_FDC    = 3'd6,
    CART_SEL_EMPTY  = 3'd7
  } cart_sel_t;

  // Selection codes that need the slot's extended-type enable bit.
  localparam logic [7:0] EXT_TYP_MASK = 8'b0011_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REQ    = 2'd2
  } cfg_state_t;

  // Per-slot tuple whose changes trigger a reload.
  typedef struct packed {
    cart_typ_t   typ;
    mapper_typ_t mapper;
    logic [2:0]  sram;
  } slot_track_t;

endpackage

`default_nettype wire

// File: rtl/cart_slot_decode.sv
//------------------------------------------------------------------------------
// cart_slot_decode
//   Combinational decoder for one cartridge slot: OSD selection codes to a
//   configuration record and OSD hide flags.
//   Ports:
//     msx_type_i      machine type
//     slot_code_i     3-bit type selection
//     mapper_code_i   4-bit mapper selection
//     sram_code_i     3-bit SRAM size selection
//     conf_o          decoded configuration record
//     rom_load_hide_o type is not ROM
//     sram_hide_o     SRAM field does not apply
//     fdc_o           decoded type is FDC
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cart_slot_decode
  import cart_slot_config_pkg::*;
#(
  parameter int SLOT_IDX = 0,
  parameter int FDC_SLOT = 0,
  parameter bit EXT_EN   = 1'b0,
  parameter bit SRAM_EN  = 1'b0
) (
  input  MSX_typ_t     msx_type_i,
  input  logic [2:0]   slot_code_i,
  input  logic [3:0]   mapper_code_i,
  input  logic [2:0]   sram_code_i,
  output config_cart_t conf_o,
  output logic         rom_load_hide_o,
  output logic         sram_hide_o,
  output logic         fdc_o
);

  localparam bit FDC_OK = (SLOT_IDX == FDC_SLOT);

  cart_sel_t  w_sel;
  cart_typ_t  w_typ;
  logic [7:0] w_sram_size;
  logic       w_is_rom;

  assign w_sel = cart_sel_t'(slot_code_i);

  always_comb begin
    w_typ = CART_TYP_EMPTY;
    case (w_sel)
      CART_SEL_FDC:   w_typ = (FDC_OK && msx_type_i != MSX2) ? CART_TYP_FDC : CART_TYP_EMPTY;
      CART_SEL_EMPTY: w_typ = CART_TYP_EMPTY;
      // Remaining codes map 1:1 unless they are extended types on a slot
      // that does not support them.
      default:        w_typ = (EXT_TYP_MASK[slot_code_i] && !EXT_EN) ? CART_TYP_EMPTY
                                                                     : cart_typ_t'(slot_code_i);
    endcase
  end

  assign w_is_rom = (w_typ == CART_TYP_ROM);

  // Codes 1..6 select 1..32 kB; auto (0) and none (7) leave the size at 0.
  always_comb begin
    w_sram_size = 8'd0;
    if (SRAM_EN && w_is_rom && mapper_code_i >= 4'd2 &&
        sram_code_i >= 3'd1 && sram_code_i <= 3'd6) begin
      w_sram_size = 8'd1 << (sram_code_i - 3'd1);
    end
  end

  assign conf_o = '{typ:                w_typ,
                    selected_mapper:    mapper_code_i + 4'd2,
                    selected_sram_size: w_sram_size};

  assign rom_load_hide_o = !w_is_rom;
  assign sram_hide_o     = !SRAM_EN || !w_is_rom || (mapper_code_i == 4'd0);
  assign fdc_o           = (w_typ == CART_TYP_FDC);

endmodule

`default_nettype wire

// File: rtl/cart_slot_config.sv
//------------------------------------------------------------------------------
// cart_slot_config
//   Cartridge-slot configuration manager. Registers the per-slot decode and
//   raises a held reload request once a configuration change has stayed
//   stable for SETTLE_CYCLES cycles; the request is retired by reload_ack.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     msx_type              machine type
//     slot_sel/mapper_sel/sram_sel  per-slot OSD selections (slot i at 3i / 4i)
//     cart_conf[SLOTS]      registered slot configuration
//     rom_load_hide         per-slot: type is not ROM
//     sram_hide             per-slot: SRAM field does not apply
//     fdc_enabled           MSX2 or any slot decoded as FDC
//     reload_req            settled change pending (held until ack)
//     reload_ack            request consumed
//     changed_mask          slots differing from baseline while reload_req
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cart_slot_config
  import cart_slot_config_pkg::*;
#(
  parameter int         SLOTS         = 2,
  parameter int         FDC_SLOT      = 0,
  parameter logic [3:0] EXT_MASK      = 4'b0001,
  parameter logic [3:0] SRAM_MASK     = 4'b0001,
  parameter int         SETTLE_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  MSX_typ_t           msx_type,
  input  logic [SLOTS*3-1:0] slot_sel,
  input  logic [SLOTS*4-1:0] mapper_sel,
  input  logic [SLOTS*3-1:0] sram_sel,
  output config_cart_t       cart_conf [SLOTS],
  output logic [SLOTS-1:0]   rom_load_hide,
  output logic [SLOTS-1:0]   sram_hide,
  output logic               fdc_enabled,
  output logic               reload_req,
  input  logic               reload_ack,
  output logic [SLOTS-1:0]   changed_mask
);

  localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  config_cart_t [SLOTS-1:0] conf_d, conf_q;
  slot_track_t  [SLOTS-1:0] cur_d, cur_q, base_q, snap_q;
  logic [SLOTS-1:0]         rom_hide_d, rom_hide_q;
  logic [SLOTS-1:0]         sram_hide_d, sram_hide_q;
  logic [SLOTS-1:0]         fdc_hit_d;
  logic                     fdc_q;
  logic [SLOTS-1:0]         mask_d, mask_q;
  logic                     req_q;
  logic [CNT_W-1:0]         cnt_q;
  cfg_state_t               state_q;

  generate
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      cart_slot_decode #(
        .SLOT_IDX (i),
        .FDC_SLOT (FDC_SLOT),
        .EXT_EN   (EXT_MASK[i]),
        .SRAM_EN  (SRAM_MASK[i])
      ) u_decode (
        .msx_type_i      (msx_type),
        .slot_code_i     (slot_sel[3*i +: 3]),
        .mapper_code_i   (mapper_sel[4*i +: 4]),
        .sram_code_i     (sram_sel[3*i +: 3]),
        .conf_o          (conf_d[i]),
        .rom_load_hide_o (rom_hide_d[i]),
        .sram_hide_o     (sram_hide_d[i]),
        .fdc_o           (fdc_hit_d[i])
      );

      // The raw SRAM code is tracked (not the decoded size) so that changing
      // it is noticed even while the size does not apply.
      assign cur_d[i] = '{typ:    conf_d[i].typ,
                          mapper: conf_d[i].selected_mapper,
                          sram:   sram_sel[3*i +: 3]};

      assign cart_conf[i] = conf_q[i];
    end
  endgenerate

  always_comb begin
    mask_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      mask_d[i] = (snap_q[i] != base_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    // Decode registers follow the inputs in every cycle, including reset.
    conf_q      <= conf_d;
    cur_q       <= cur_d;
    rom_hide_q  <= rom_hide_d;
    sram_hide_q <= sram_hide_d;
    fdc_q       <= (msx_type == MSX2) || (|fdc_hit_d);

    if (reset) begin
      base_q  <= cur_d;
      snap_q  <= cur_d;
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cur_q != base_q) begin
            snap_q  <= cur_q;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cur_q == base_q) begin
            state_q <= IDLE;
          end else if (cur_q != snap_q) begin
            // Still scrolling: restart the stability window.
            snap_q <= cur_q;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            mask_q  <= mask_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REQ: begin
          // Inputs are ignored here; IDLE re-compares against the new baseline.
          if (reload_ack) begin
            base_q  <= snap_q;
            state_q <= IDLE;
            req_q   <= 1'b0;
            mask_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          mask_q  <= '0;
        end
      endcase
    end
  end

  assign rom_load_hide = rom_hide_q;
  assign sram_hide     = sram_hide_q;
  assign fdc_enabled   = fdc_q;
  assign reload_req    = req_q;
  assign changed_mask  = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_cart_slot_config.sv
//------------------------------------------------------------------------------
// tb_cart_slot_config
//   Self-checking bench for cart_slot_config (SLOTS=2, SETTLE_CYCLES=8).
//   The reference model decodes selections arithmetically and predicts the
//   reload request with a sliding stability window over the registered tuple.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cart_slot_config;
  import cart_slot_config_pkg::*;

  localparam int         NS       = 2;
  localparam int         S        = 8;
  localparam int         FDC_M    = 0;
  localparam logic [3:0] EXT_M    = 4'b0001;
  localparam logic [3:0] SRAM_M   = 4'b0001;

  logic              clk = 1'b0;
  logic              reset;
  MSX_typ_t          msx_type;
  logic [NS*3-1:0]   slot_sel;
  logic [NS*4-1:0]   mapper_sel;
  logic [NS*3-1:0]   sram_sel;
  config_cart_t      cart_conf [NS];
  logic [NS-1:0]     rom_load_hide, sram_hide, changed_mask;
  logic              fdc_enabled, reload_req, reload_ack;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [19:0] m_base, m_snap;
  logic [19:0] hist[$];
  bit          m_req;
  logic [1:0]  m_mask;
  int          edge_n = 0;
  int          epoch  = 0;
  bit          saw_req;

  cart_slot_config #(
    .SLOTS(NS), .FDC_SLOT(FDC_M), .EXT_MASK(EXT_M), .SRAM_MASK(SRAM_M),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .msx_type(msx_type), .slot_sel(slot_sel),
    .mapper_sel(mapper_sel), .sram_sel(sram_sel), .cart_conf(cart_conf),
    .rom_load_hide(rom_load_hide), .sram_hide(sram_hide),
    .fdc_enabled(fdc_enabled), .reload_req(reload_req),
    .reload_ack(reload_ack), .changed_mask(changed_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_type(int slot, int code, bit msx2);
    if (code <= 3) return code;
    if (code == 4 || code == 5) return EXT_M[slot] ? code : 7;
    if (code == 6) return (slot == FDC_M && !msx2) ? 6 : 7;
    return 7;
  endfunction

  function automatic int m_conf(int slot);
    int t, m, s, size;
    t = m_type(slot, int'(slot_sel[3*slot +: 3]), msx_type == MSX2);
    m = int'(mapper_sel[4*slot +: 4]);
    s = int'(sram_sel[3*slot +: 3]);
    size = (SRAM_M[slot] && t == 0 && m >= 2 && s >= 1 && s <= 6) ? (1 << (s - 1)) : 0;
    return t * 4096 + ((m + 2) % 16) * 256 + size;
  endfunction

  function automatic logic [19:0] m_tuple();
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      r[10*i +: 10] = 10'(m_type(i, int'(slot_sel[3*i +: 3]), msx_type == MSX2) * 128 +
                          ((int'(mapper_sel[4*i +: 4]) + 2) % 16) * 8 +
                          int'(sram_sel[3*i +: 3]));
    end
    return r;
  endfunction

  // One clock: advance the model with the inputs sampled at the edge, then
  // compare every output 1 time unit later.
  task automatic step();
    logic [19:0] c_now;
    int          ec [NS];
    logic [1:0]  e_rom, e_sram;
    bit          e_fdc, win;
    @(posedge clk);
    edge_n++;
    c_now = m_tuple();
    e_fdc = (msx_type == MSX2);
    for (int i = 0; i < NS; i++) begin
      ec[i]     = m_conf(i);
      e_rom[i]  = (ec[i] / 4096) != 0;
      e_sram[i] = !SRAM_M[i] || (ec[i] / 4096) != 0 || mapper_sel[4*i +: 4] == 4'd0;
      if (ec[i] / 4096 == 6) e_fdc = 1'b1;
    end
    if (reset) begin
      m_base = c_now; m_req = 1'b0; m_mask = '0; epoch = edge_n;
    end else if (m_req) begin
      if (reload_ack) begin
        m_req = 1'b0; m_base = m_snap; m_mask = '0; epoch = edge_n;
      end
    end else begin
      win = (hist.size() == S + 1) && (edge_n - epoch >= S + 1) && (hist[0] != m_base);
      foreach (hist[k]) if (hist[k] != hist[0]) win = 1'b0;
      if (win) begin
        m_req  = 1'b1;
        m_snap = hist[0];
        for (int i = 0; i < NS; i++) m_mask[i] = (m_snap[10*i +: 10] != m_base[10*i +: 10]);
      end
    end
    hist.push_back(c_now);
    if (hist.size() > S + 1) void'(hist.pop_front());
    #1;
    for (int i = 0; i < NS; i++) check($sformatf("conf%0d", i), 32'(cart_conf[i]), 32'(ec[i]));
    check("rom_hide", 32'(rom_load_hide), 32'(e_rom));
    check("sram_hide", 32'(sram_hide), 32'(e_sram));
    check("fdc", 32'(fdc_enabled), 32'(e_fdc));
    check("req", 32'(reload_req), 32'(m_req));
    check("mask", 32'(changed_mask), 32'(m_mask));
    if (reload_req) saw_req = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_req(input int bound, output int lat);
    lat = 0;
    while (!reload_req && lat < bound) begin
      step();
      lat++;
    end
    check("req_timeout", 32'(reload_req), 32'd1);
  endtask

  task automatic ack_req();
    reload_ack = 1'b1;
    step();
    reload_ack = 1'b0;
  endtask

  task automatic settle_and_ack();
    int lat;
    wait_req(40, lat);
    ack_req();
  endtask

  // Random selection change that is guaranteed to alter the tracked tuple.
  task automatic rand_change(input bit avoid_base);
    logic [19:0] prev;
    prev = m_tuple();
    for (int k = 0; k < 200; k++) begin
      slot_sel   = 6'($urandom);
      mapper_sel = 8'($urandom);
      sram_sel   = 6'($urandom);
      if (m_tuple() != prev && !(avoid_base && m_tuple() == m_base)) break;
    end
  endtask

  initial begin
    int lat;
    logic [1:0] emask;
    reset      = 1'b1;
    reload_ack = 1'b0;
    msx_type   = MSX1;
    slot_sel   = '0;
    mapper_sel = {4'd4, 4'd4};
    sram_sel   = {3'd3, 3'd3};
    run(3);
    reset = 1'b0;
    step();
    // reset capture
    check("rst_conf0", 32'(cart_conf[0]), 32'h0604);
    check("rst_conf1", 32'(cart_conf[1]), 32'h0600);
    check("rst_req", 32'(reload_req), 32'd0);
    run(12);

    // settle: slot 1 ROM -> SCC
    slot_sel[5:3] = 3'd1;
    wait_req(40, lat);
    check("settle_lat", 32'(lat), 32'd10);
    check("settle_mask", 32'(changed_mask), 32'b10);
    ack_req();
    check("settle_drop", 32'(reload_req), 32'd0);
    saw_req = 1'b0;
    run(20);
    check("settle_norereq", 32'(saw_req), 32'd0);

    // revert within the window
    slot_sel[2:0] = 3'd2;
    run(3);
    slot_sel[2:0] = 3'd0;
    saw_req = 1'b0;
    run(20);
    check("revert_noreq", 32'(saw_req), 32'd0);

    // bounce: a change every 5 cycles
    for (int k = 0; k < 8; k++) begin
      rand_change(1'b0);
      run(5);
    end
    rand_change(1'b1);
    for (int i = 0; i < NS; i++)
      emask[i] = (m_tuple() >> (10*i)) % 1024 != (m_base >> (10*i)) % 1024;
    wait_req(40, lat);
    check("bounce_lat", 32'(lat), 32'd10);
    check("bounce_mask", 32'(changed_mask), 32'(emask));
    ack_req();

    // masking
    msx_type   = MSX1;
    slot_sel   = {3'd4, 3'd0};
    mapper_sel = {4'd1, 4'd3};
    step();
    check("ext_mask_typ1", 32'(cart_conf[1].typ), 32'd7);
    settle_and_ack();
    slot_sel[2:0] = 3'd6;
    msx_type      = MSX2;
    step();
    check("fdc_msx2_typ0", 32'(cart_conf[0].typ), 32'd7);
    check("fdc_msx2_en", 32'(fdc_enabled), 32'd1);
    settle_and_ack();
    msx_type = MSX1;
    step();
    check("fdc_msx1_typ0", 32'(cart_conf[0].typ), 32'd6);
    check("fdc_msx1_en", 32'(fdc_enabled), 32'd1);
    settle_and_ack();

    // change during REQ, then reset mid-REQ
    slot_sel[2:0] = 3'd1;
    wait_req(40, lat);
    slot_sel[2:0] = 3'd2;
    run(2);
    check("req_hold", 32'(reload_req), 32'd1);
    ack_req();
    check("req_drop", 32'(reload_req), 32'd0);
    wait_req(40, lat);
    check("rereq_lat", 32'(lat), 32'(S + 1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_midreq", 32'(reload_req), 32'd0);
    saw_req = 1'b0;
    run(20);
    check("rst_newbase", 32'(saw_req), 32'd0);

    // free-running random traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        rand_change(1'b0);
        if ($urandom_range(0, 3) == 0) msx_type = MSX_typ_t'($urandom_range(0, 1));
      end
      reload_ack = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      step();
    end
    reload_ack = 1'b0;
    reset      = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cart_slot_config.md
# cart_slot_config

Parametrised cartridge-slot configuration manager for the MSX core. Decodes per-slot OSD selections (slot type, mapper, SRAM size) into registered `MSX::config_cart_t` records and OSD hide flags for `SLOTS` cartridge slots. Detects configuration changes, waits for them to stay stable for a settle window (menu scrolling), then raises a held reload request. The request is retired by an acknowledge handshake from the reload/reset controller.

## Interface
Parameters:
- `SLOTS`, 2: number of cartridge slots (1..4).
- `FDC_SLOT`, 0: slot index allowed to select FDC; -1 means no slot can.
- `EXT_MASK`, 'b01: per-slot bit; 1 means MFRSD and GameMaster2 types are selectable in that slot.
- `SRAM_MASK`, 'b01: per-slot bit; 1 means the SRAM size selection applies to that slot.
- `SETTLE_CYCLES`, 1024: number of stable cycles required before a request (≥1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `msx_type`  in  MSX_typ_t  machine type.
- `slot_sel`  in  SLOTS*3  per-slot type code, slot i at [3i+2:3i].
- `mapper_sel`  in  SLOTS*4  per-slot mapper code.
- `sram_sel`  in  SLOTS*3  per-slot SRAM code.
- `cart_conf[SLOTS]`  out  config_cart_t  decoded slot configuration.
- `rom_load_hide`  out  SLOTS  1 when the slot type is not ROM.
- `sram_hide`  out  SLOTS  1 when the SRAM field does not apply.
- `fdc_enabled`  out  1  1 when `msx_type`==MSX2 or any slot type is FDC.
- `reload_req`  out  1  a settled change is pending.
- `reload_ack`  in  1  the controller has consumed the request.
- `changed_mask`  out  SLOTS  slots that differ from the baseline; valid while `reload_req` is high.

## Operation
Type codes: ROM=0, SCC=1, SCC+=2, FM-PAC=3, MFRSD=4, GM2=5, FDC=6, EMPTY=7.

Type decode per slot i:
- Codes 0–3 pass through unchanged.
- Codes 4–5 pass if `EXT_MASK[i]`, else EMPTY.
- Code 6 gives FDC if i==`FDC_SLOT` and `msx_type`!=MSX2, else EMPTY.
- Code 7 gives EMPTY.

Mapper decode: `selected_mapper` = `mapper_sel` + 2, in 4-bit arithmetic (wraps modulo 16).

SRAM size decode:
- `selected_sram_size` = 8'd1 << (`sram_sel`−1) kB when all of these hold: `SRAM_MASK[i]`, type==ROM, `mapper_sel`≥2, and `sram_sel` in 1..6.
- Otherwise 0. Code 0 (auto) and code 7 (none) both give 0.

Hide flags:
- `rom_load_hide[i]` = type != ROM.
- `sram_hide[i]` = !`SRAM_MASK[i]` | type != ROM | `mapper_sel`==0.

Change tracking:
- The tracked per-slot tuple is {type, selected_mapper, sram_sel}.
- Registers: `cur` (registered decode), `base` (baseline), `snap` (candidate), and a settle counter.

FSM:
- IDLE: if `cur`!=`base`, set `snap`<=`cur`, counter<=0, go to SETTLE.
- SETTLE, evaluated in priority order:
  1. If `cur`==`base`, go to IDLE (change reverted, no request).
  2. Else if `cur`!=`snap`, set `snap`<=`cur` and counter<=0.
  3. Else if counter==`SETTLE_CYCLES`−1, go to REQ.
  4. Else counter+1.
- REQ: `reload_req`=1. `changed_mask[i]` = `snap[i]`!=`base[i]`.
  - Input changes are ignored while in REQ.
  - On `reload_ack`, set `base`<=`snap` and go to IDLE.
  - In IDLE, `cur` is compared against the new `base`, so a change made during REQ starts a fresh settle.
- `reload_ack` outside REQ is ignored.
- The counter width is $clog2(`SETTLE_CYCLES`+1).

## Timing
- Decode latency is 1 cycle from input change to `cart_conf`, hide flags and `fdc_enabled`.
- On each reset cycle:
  - `cur` and `base` both load the current decode; outputs show the current decode one cycle later.
  - `snap` loads the current decode.
  - State goes to IDLE; `reload_req`=0, `changed_mask`=0, counter=0.
- A reset asserted mid-SETTLE or mid-REQ drops any pending request.
- Request latency: `reload_req` rises exactly `SETTLE_CYCLES`+2 cycles after the last input change, given stable inputs (1 cycle decode, 1 cycle IDLE→SETTLE, then the settle count).
- `reload_req` falls in the cycle after `reload_ack` is sampled high.
- `reload_req` and `changed_mask` are registered outputs.
- Simultaneous `reload_ack` and an input change: the ack wins; the change is detected from IDLE.

## Structure
- Add to the MSX package: `cart_sel_t` type-code enum, `EXT_TYP_MASK` constant, and the `cfg_state_t` {IDLE, SETTLE, REQ} enum.
- Reuse the existing `config_cart_t`, `cart_typ_t` and `mapper_typ_t`.
- Sub-module `cart_slot_decode`: combinational per-slot decoder, instantiated `SLOTS` times with slot index, `EXT_MASK` bit and `SRAM_MASK` bit as parameters.
- The top level holds the registers, comparators and FSM.

## Test plan
- **Reset capture:** `slot_sel`=0, `mapper_sel`=4, `sram_sel`=3, SLOTS=2 → `cart_conf[0]` typ ROM, mapper 6, `selected_sram_size` 4; `reload_req` 0 after reset release.
- **Settle:** `SETTLE_CYCLES`=8; change slot 1 type 0→1 → `reload_req` rises exactly 10 cycles later with `changed_mask`='b10; ack → low next cycle; no re-request.
- **Revert:** change slot 0 type, then restore it after 3 cycles → `reload_req` never asserts.
- **Bounce:** change inputs every 5 cycles for 40 cycles with `SETTLE_CYCLES`=8 → request arrives 10 cycles after the last change; `changed_mask` reflects the final values.
- **Masking:**
  - slot 1 code 4 with `EXT_MASK`='b01 → slot 1 EMPTY.
  - slot 0 code 6 with `msx_type`=MSX2 → EMPTY, but `fdc_enabled`=1.
  - slot 0 code 6 with `msx_type`=MSX1 → FDC, `fdc_enabled`=1.
- **Change during REQ:** alter slot 0 while `reload_req`=1, then ack → request drops, then re-asserts `SETTLE_CYCLES`+1 cycles after the ack; reset mid-REQ → `reload_req`=0 with the new baseline.
